fp_minmax_stage: RTL

- Pipelined FMIN/FMAX issue-and-retire stage of the FPU, between FP operand read and FP writeback.
- Accepts operands and opcode under a valid/ready handshake, NaN-unboxes single-precision operands and sign-flips them for min.
- Drives the combinational max units (one 64-bit, one 32-bit instance), then applies RISC-V NaN, signed-zero and flag rules.
- Registers the NaN-boxed result with the NV flag and destination tag.

---
 rtl/fp_minmax_stage.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fp_minmax_stage.sv
// fp_minmax_stage: pipelined FMIN/FMAX issue-and-retire stage.
//   S1 holds NaN-unboxed operands plus their classification; the external
//   max units sit combinationally between S1 and S2. FMIN is computed as a
//   max of sign-flipped operands, and the sign is restored on capture.
//   The RISC-V NaN, signed-zero and NV rules are applied when S2 captures.
// Ports:
//   clk, rst (sync, active high), flush (sync pipeline kill)
//   in_*            : operation request (valid/ready), op 0=FMIN 1=FMAX,
//                     fmt 0=S 1=D, raw 64-bit register operands, dest tag
//   unit_a/b/res    : 64-bit external max unit (driven with zeros for S)
//   unit32_a/b/res  : 32-bit external max unit (driven with zeros for D)
//   out_*           : registered result (valid/ready), NaN-boxed for S,
//                     fflags {NV,DZ,OF,UF,NX}, dest tag
module fp_minmax_stage #(
    parameter int FLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic             in_fmt,
    input  logic [FLEN-1:0]  in_rs1,
    input  logic [FLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_rd,
    output logic [FLEN-1:0]  unit_a,
    output logic [FLEN-1:0]  unit_b,
    input  logic [FLEN-1:0]  unit_res,
    output logic [31:0]      unit32_a,
    output logic [31:0]      unit32_b,
    input  logic [31:0]      unit32_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FLEN-1:0]  out_data,
    output logic [4:0]       out_fflags,
    output logic [TAG_W-1:0] out_rd
);

    localparam logic [63:0] CANON_D = 64'h7FF8000000000000;
    localparam logic [31:0] CANON_S = 32'h7FC00000;
    localparam logic [31:0] BOX     = 32'hFFFFFFFF;

    typedef struct packed {
        logic             op;
        logic             fmt;
        logic [TAG_W-1:0] rd;
        logic [63:0]      a;
        logic [63:0]      b;
        logic             nan_a;
        logic             nan_b;
        logic             snan;
        logic             zero_a;
        logic             zero_b;
    } s1_t;

    // An S operand that is not properly boxed reads as the canonical qNaN.
    function automatic logic [63:0] unbox(input logic fmt, input logic [63:0] v);
        if (!fmt && v[63:32] != BOX)
            return {BOX, CANON_S};
        return v;
    endfunction

    // Returns {nan, snan, zero}.
    function automatic logic [2:0] classify(input logic fmt, input logic [63:0] v);
        logic exp_ones, man_nz, man_msb, is_zero;
        if (fmt) begin
            exp_ones = &v[62:52];
            man_nz   = |v[51:0];
            man_msb  = v[51];
            is_zero  = ~|v[62:0];
        end else begin
            exp_ones = &v[30:23];
            man_nz   = |v[22:0];
            man_msb  = v[22];
            is_zero  = ~|v[30:0];
        end
        return {exp_ones & man_nz, exp_ones & man_nz & ~man_msb, is_zero};
    endfunction

    s1_t         s1;
    logic        s1_valid;
    logic        s2_free;
    logic        flip;
    logic        sign_a, sign_b;
    logic [63:0] ua, ub;
    logic [2:0]  ca, cb;
    logic [63:0] res;

    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !rst && !flush && (!s1_valid || s2_free);

    assign ua = unbox(in_fmt, in_rs1);
    assign ub = unbox(in_fmt, in_rs2);
    assign ca = classify(in_fmt, ua);
    assign cb = classify(in_fmt, ub);

    // FMIN(a,b) = -FMAX(-a,-b); flip the sign on the way in and back out.
    assign flip   = !s1.op;
    assign sign_a = s1.fmt ? s1.a[63] : s1.a[31];
    assign sign_b = s1.fmt ? s1.b[63] : s1.b[31];

    assign unit_a   = s1.fmt  ? (s1.a ^ {flip, 63'b0}) : '0;
    assign unit_b   = s1.fmt  ? (s1.b ^ {flip, 63'b0}) : '0;
    assign unit32_a = !s1.fmt ? (s1.a[31:0] ^ {flip, 31'b0}) : '0;
    assign unit32_b = !s1.fmt ? (s1.b[31:0] ^ {flip, 31'b0}) : '0;

    always_comb begin
        res = '0;
        if (s1.fmt) res = unit_res ^ {flip, 63'b0};
        else        res = {BOX, unit32_res ^ {flip, 31'b0}};

        if (s1.nan_a && s1.nan_b)
            res = s1.fmt ? CANON_D : {BOX, CANON_S};
        else if (s1.nan_a)
            res = s1.fmt ? s1.b : {BOX, s1.b[31:0]};
        else if (s1.nan_b)
            res = s1.fmt ? s1.a : {BOX, s1.a[31:0]};
        else if (s1.zero_a && s1.zero_b && (sign_a != sign_b))
            // max picks +0, min picks -0: the sign is exactly 'flip'.
            res = s1.fmt ? {flip, 63'b0} : {BOX, flip, 31'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= '0;
            s1_valid   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_fflags <= '0;
            out_rd     <= '0;
        end else if (flush) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (s2_free) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data   <= res;
                    out_fflags <= {s1.snan, 4'b0};
                    out_rd     <= s1.rd;
                end
            end
            // in_ready already implies S1 is empty or draining this cycle.
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1.op     <= in_op;
                    s1.fmt    <= in_fmt;
                    s1.rd     <= in_rd;
                    s1.a      <= ua;
                    s1.b      <= ub;
                    s1.nan_a  <= ca[2];
                    s1.nan_b  <= cb[2];
                    s1.snan   <= ca[1] | cb[1];
                    s1.zero_a <= ca[0];
                    s1.zero_b <= cb[0];
                end
            end
        end
    end

endmodule
